// File: rtl/hwpe_stream_tcdm_reader.sv
// Strided TCDM read master: issues one word request per grant, buffers the
// responses in a small FIFO and presents them as a valid/ready stream.
module hwpe_stream_tcdm_reader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [CNT_WIDTH-1:0] word_count_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tcdm_req_o,
  input  logic                 tcdm_gnt_i,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_data_o,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  output logic                 stream_valid_o,
  input  logic                 stream_ready_i,
  output logic [31:0]          stream_data_o,
  output logic [3:0]           stream_strb_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [AW:0]          PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             addr_q, stride_q;
  logic [CNT_WIDTH-1:0]    count_q, issued_q;
  logic                    inflight_q, zdone_q;
  logic [AW:0]             wptr_q, rptr_q, occ;
  logic [FIFO_DEPTH-1:0][31:0] mem_q;
  logic                    hs, push, pop, credit_ok, drain_done;

  assign occ       = wptr_q - rptr_q;
  assign hs        = tcdm_req_o & tcdm_gnt_i;
  assign pop       = stream_valid_o & stream_ready_i;
  assign push      = tcdm_r_valid_i & ~clear_i;
  // A word popped this cycle does not free a credit until the next one.
  assign credit_ok = (32'(occ) + 32'(inflight_q)) < FIFO_DEPTH;
  assign drain_done = (state_q == DRAIN) & ~inflight_q & ~clear_i &
                      ((occ == '0) | ((occ == PTR_ONE) & pop));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i && word_count_i != '0) state_d = RUN;
      RUN:     if (hs && (issued_q + CNT_ONE) == count_q) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_comb begin
    busy_o         = (state_q != IDLE);
    done_o         = zdone_q | drain_done;
    tcdm_req_o     = (state_q == RUN) & (issued_q < count_q) & credit_ok & ~clear_i;
    tcdm_add_o     = tcdm_req_o ? addr_q : 32'h0;
    tcdm_wen_o     = 1'b1;
    tcdm_be_o      = 4'hF;
    tcdm_data_o    = 32'h0;
    stream_valid_o = (occ != '0);
    stream_data_o  = stream_valid_o ? mem_q[rptr_q[AW-1:0]] : 32'h0;
    stream_strb_o  = {4{stream_valid_o}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      stride_q   <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      zdone_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else if (clear_i) begin
      issued_q   <= '0;
      inflight_q <= 1'b0;
      zdone_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      zdone_q    <= (state_q == IDLE) & start_i & (word_count_i == '0);
      inflight_q <= hs;
      if (state_q == IDLE && start_i) begin
        addr_q   <= base_addr_i;
        stride_q <= stride_i;
        count_q  <= word_count_i;
        issued_q <= '0;
      end else if (hs) begin
        addr_q   <= addr_q + stride_q;
        issued_q <= issued_q + CNT_ONE;
      end
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= tcdm_r_data_i;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) tcdm_r_valid_i |-> inflight_q)
    else $error("tcdm_r_valid_i without an outstanding request");

endmodule

// File: tb/tb_hwpe_stream_tcdm_reader.sv
// Bench for hwpe_stream_tcdm_reader: a 1-cycle TCDM responder plus a
// job-level model (address list base+i*stride, data in issue order).
module tb_hwpe_stream_tcdm_reader;
  localparam int FD = 4;
  localparam int CW = 16;

  logic clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0, start_i = 1'b0;
  logic [31:0] base_addr_i = '0, stride_i = '0;
  logic [CW-1:0] word_count_i = '0;
  logic busy_o, done_o, tcdm_req_o, tcdm_wen_o, stream_valid_o;
  logic tcdm_gnt_i = 1'b0, tcdm_r_valid_i = 1'b0, stream_ready_i = 1'b0;
  logic [31:0] tcdm_add_o, tcdm_data_o, stream_data_o, tcdm_r_data_i = '0;
  logic [3:0] tcdm_be_o, stream_strb_o;

  int n_tests = 0, n_fail = 0;
  logic s_req, s_valid, s_done, s_busy;
  logic [31:0] s_add, s_data;
  logic [3:0] s_strb;
  logic [31:0] gnt_addr_q[$];
  logic [31:0] got_q[$];
  int n_gnt, n_pop, n_done;
  bit rnd_gnt = 0, rnd_rdy = 0;

  always #5 clk_i = ~clk_i;

  hwpe_stream_tcdm_reader #(.FIFO_DEPTH(FD), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .word_count_i(word_count_i),
    .busy_o(busy_o), .done_o(done_o), .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o),
    .tcdm_data_o(tcdm_data_o), .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
    .stream_data_o(stream_data_o), .stream_strb_o(stream_strb_o)
  );

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // One clock: sample at negedge, record handshakes, answer grants after the edge.
  task automatic tick();
    logic hs;
    logic [31:0] ha;
    if (rnd_gnt) tcdm_gnt_i = ($urandom_range(0, 3) != 0);
    if (rnd_rdy) stream_ready_i = ($urandom_range(0, 2) != 0);
    @(negedge clk_i);
    s_req = tcdm_req_o; s_add = tcdm_add_o; s_valid = stream_valid_o;
    s_data = stream_data_o; s_strb = stream_strb_o; s_done = done_o; s_busy = busy_o;
    hs = tcdm_req_o & tcdm_gnt_i;
    ha = tcdm_add_o;
    if (hs) begin gnt_addr_q.push_back(ha); n_gnt++; end
    if (stream_valid_o & stream_ready_i) begin got_q.push_back(stream_data_o); n_pop++; end
    if (done_o) n_done++;
    @(posedge clk_i); #1;
    tcdm_r_valid_i = hs;
    tcdm_r_data_i  = hs ? rdata(ha) : 32'hDEAD_BEEF;
  endtask

  task automatic start_job(input logic [31:0] b, input logic [31:0] s, input int cnt);
    gnt_addr_q.delete(); got_q.delete();
    n_gnt = 0; n_pop = 0; n_done = 0;
    base_addr_i = b; stride_i = s; word_count_i = CW'(cnt); start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      if (s_done) ok = 1;
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({busy_o, done_o, tcdm_req_o, stream_valid_o} !== 4'b0 || tcdm_add_o !== 32'h0 ||
        stream_data_o !== 32'h0 || stream_strb_o !== 4'h0 || tcdm_data_o !== 32'h0)
      begin n_fail++; $display("FAIL reset_outputs: busy=%b done=%b req=%b valid=%b add=%h data=%h strb=%h, all must be 0",
        busy_o, done_o, tcdm_req_o, stream_valid_o, tcdm_add_o, stream_data_o, stream_strb_o); end
    n_tests++;
    if (tcdm_wen_o !== 1'b1 || tcdm_be_o !== 4'hF)
      begin n_fail++; $display("FAIL reset_consts: wen=%b be=%h, want 1/F", tcdm_wen_o, tcdm_be_o); end
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ev;
    tcdm_gnt_i = 1'b1; stream_ready_i = 1'b1;
    start_job(32'h1000, 32'd4, 4);
    n_tests++;
    if (s_req !== 1'b0 || s_done !== 1'b0)
      begin n_fail++; $display("FAIL basic_c0: req=%b done=%b, want 0/0", s_req, s_done); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (s_req !== (k <= 4) || (k <= 4 && s_add !== 32'h1000 + 32'(4 * (k - 1))))
        begin n_fail++; $display("FAIL basic_req c%0d: req=%b add=%h", k, s_req, s_add); end
      ev = (k >= 3 && k <= 6);
      n_tests++;
      if (s_valid !== ev || s_strb !== (ev ? 4'hF : 4'h0) ||
          (ev && s_data !== rdata(32'h1000 + 32'(4 * (k - 3)))))
        begin n_fail++; $display("FAIL basic_stream c%0d: valid=%b strb=%h data=%h want valid=%b", k, s_valid, s_strb, s_data, ev); end
      n_tests++;
      if (s_done !== (k == 6) || s_busy !== (k <= 6))
        begin n_fail++; $display("FAIL basic_done c%0d: done=%b busy=%b", k, s_done, s_busy); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] b, s;
    bit ok;
    b = $urandom & 32'hFFFF_FFFC; s = 32'd8;
    tcdm_gnt_i = 1'b1; stream_ready_i = 1'b0;
    start_job(b, s, 8);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 3) begin
        n_tests++;
        if (s_valid !== 1'b1 || s_data !== rdata(b))
          begin n_fail++; $display("FAIL bp_head c%0d: valid=%b data=%h want %h", k, s_valid, s_data, rdata(b)); end
      end
    end
    n_tests++;
    if (n_gnt != FD || s_req !== 1'b0)
      begin n_fail++; $display("FAIL bp_credit: grants=%0d req=%b, want %0d/0", n_gnt, s_req, FD); end
    stream_ready_i = 1'b1;
    wait_done(100, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout: done never seen"); end
    n_tests++;
    if (got_q.size() != 8 || n_gnt != 8)
      begin n_fail++; $display("FAIL bp_count: words=%0d grants=%0d want 8", got_q.size(), n_gnt); end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      n_tests++;
      if (got_q[i] !== rdata(b + 32'(i) * s))
        begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], rdata(b + 32'(i) * s)); end
    end
  endtask

  task automatic test_gnt_stall();
    logic [31:0] b;
    bit ok;
    b = $urandom & 32'hFFFF_FFFC;
    tcdm_gnt_i = 1'b1; stream_ready_i = 1'b1;
    start_job(b, 32'd4, 6);
    tick(); tick();
    tcdm_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (s_req !== 1'b1 || s_add !== b + 32'd8 || n_gnt != 2)
        begin n_fail++; $display("FAIL stall[%0d]: req=%b add=%h grants=%0d want 1/%h/2", k, s_req, s_add, n_gnt, b + 32'd8); end
    end
    tcdm_gnt_i = 1'b1;
    wait_done(100, ok);
    n_tests++;
    if (!ok || got_q.size() != 6)
      begin n_fail++; $display("FAIL stall_end: done=%b words=%0d want 6", ok, got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      n_tests++;
      if (gnt_addr_q[i] !== b + 32'(4 * i) || got_q[i] !== rdata(b + 32'(4 * i)))
        begin n_fail++; $display("FAIL stall_word[%0d]: add=%h data=%h", i, gnt_addr_q[i], got_q[i]); end
    end
  endtask

  task automatic test_zero();
    tcdm_gnt_i = 1'b1;
    start_job(32'h40, 32'd4, 0);
    tick();
    n_tests++;
    if (s_done !== 1'b1 || s_req !== 1'b0 || s_busy !== 1'b0)
      begin n_fail++; $display("FAIL zero_c1: done=%b req=%b busy=%b want 1/0/0", s_done, s_req, s_busy); end
    tick();
    n_tests++;
    if (s_done !== 1'b0 || s_req !== 1'b0 || s_busy !== 1'b0 || n_gnt != 0)
      begin n_fail++; $display("FAIL zero_c2: done=%b req=%b busy=%b grants=%0d", s_done, s_req, s_busy, n_gnt); end
  endtask

  task automatic test_clear();
    bit ok;
    tcdm_gnt_i = 1'b1; stream_ready_i = 1'b0;
    start_job(32'h1000, 32'd4, 8);
    tick();
    clear_i = 1'b1; start_i = 1'b1; base_addr_i = 32'h3000; word_count_i = CW'(3);
    tick();
    clear_i = 1'b0; start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_req !== 1'b0 || s_done !== 1'b0 || s_strb !== 4'h0)
        begin n_fail++; $display("FAIL clear[%0d]: valid=%b busy=%b req=%b done=%b", k, s_valid, s_busy, s_req, s_done); end
    end
    stream_ready_i = 1'b1;
    start_job(32'h2000, 32'd4, 4);
    wait_done(100, ok);
    n_tests++;
    if (!ok || got_q.size() != 4)
      begin n_fail++; $display("FAIL clear_restart: done=%b words=%0d want 4", ok, got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      n_tests++;
      if (got_q[i] !== rdata(32'h2000 + 32'(4 * i)))
        begin n_fail++; $display("FAIL clear_data[%0d]: got %h want %h", i, got_q[i], rdata(32'h2000 + 32'(4 * i))); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp_a[4];
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    tcdm_gnt_i = 1'b1; stream_ready_i = 1'b1;
    start_job(32'hFFFF_FFF8, 32'd4, 4);
    wait_done(50, ok);
    n_tests++;
    if (!ok || gnt_addr_q.size() != 4 || got_q.size() != 4)
      begin n_fail++; $display("FAIL wrap_end: done=%b grants=%0d words=%0d", ok, gnt_addr_q.size(), got_q.size()); end
    for (int i = 0; i < gnt_addr_q.size() && i < 4; i++) begin
      n_tests++;
      if (gnt_addr_q[i] !== exp_a[i])
        begin n_fail++; $display("FAIL wrap_add[%0d]: got %h want %h", i, gnt_addr_q[i], exp_a[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] b, s;
    int cnt, g0, p0;
    bit ok;
    for (int j = 0; j < 8; j++) begin
      b = $urandom;
      case (j % 3)
        0: s = 32'd4;
        1: s = 32'hFFFF_FFFC;
        default: s = $urandom;
      endcase
      cnt = $urandom_range(1, 20);
      rnd_gnt = 1; rnd_rdy = 1;
      start_job(b, s, cnt);
      ok = 0;
      for (int k = 0; k < 400 && !ok; k++) begin
        g0 = n_gnt; p0 = n_pop;
        tick();
        if (s_req) begin
          n_tests++;
          if (g0 - p0 >= FD)
            begin n_fail++; $display("FAIL rnd_credit job%0d: req with %0d words outstanding", j, g0 - p0); end
        end
        if (s_done) ok = 1;
      end
      rnd_gnt = 0; rnd_rdy = 0;
      n_tests++;
      if (!ok || n_gnt != cnt || got_q.size() != cnt)
        begin n_fail++; $display("FAIL rnd_end job%0d: done=%b grants=%0d words=%0d want %0d", j, ok, n_gnt, got_q.size(), cnt); end
      for (int i = 0; i < cnt && i < got_q.size() && i < gnt_addr_q.size(); i++) begin
        n_tests++;
        if (gnt_addr_q[i] !== b + 32'(i) * s || got_q[i] !== rdata(b + 32'(i) * s))
          begin n_fail++; $display("FAIL rnd_word job%0d[%0d]: add=%h data=%h want add %h", j, i, gnt_addr_q[i], got_q[i], b + 32'(i) * s); end
      end
      tick();
      n_tests++;
      if (s_busy !== 1'b0 || n_done != 1)
        begin n_fail++; $display("FAIL rnd_idle job%0d: busy=%b dones=%0d want 0/1", j, s_busy, n_done); end
    end
  endtask

  task automatic test_reset_midjob();
    tcdm_gnt_i = 1'b1; stream_ready_i = 1'b0;
    start_job(32'h5000, 32'd4, 10);
    repeat (3) tick();
    rst_ni = 1'b0; tcdm_r_valid_i = 1'b0; tcdm_gnt_i = 1'b0;
    #1;
    n_tests++;
    if ({busy_o, done_o, tcdm_req_o, stream_valid_o} !== 4'b0 || tcdm_wen_o !== 1'b1 || tcdm_be_o !== 4'hF)
      begin n_fail++; $display("FAIL midreset: busy=%b done=%b req=%b valid=%b wen=%b be=%h",
        busy_o, done_o, tcdm_req_o, stream_valid_o, tcdm_wen_o, tcdm_be_o); end
    repeat (2) tick();
    rst_ni = 1'b1;
    tcdm_gnt_i = 1'b1;
    tick();
    n_tests++;
    if (s_busy !== 1'b0 || s_req !== 1'b0 || s_valid !== 1'b0)
      begin n_fail++; $display("FAIL midreset_after: busy=%b req=%b valid=%b", s_busy, s_req, s_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gnt_stall();
    test_zero();
    test_clear();
    test_wrap();
    test_random();
    test_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end
endmodule
